ps2_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the opposite direction of the keyboard scan-code receive path.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard over the shared PS/2 clock and data lines.
- Drives the lines only through open-drain style tri-states and releases them when idle, so the existing PS/2 receiver can share ps2c and ps2d.

---
 rtl/ps2_tx.sv | 138 +++++++++++++
 tb/tb_ps2_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter driving clock/data open-drain (0 or Z only).
// Optional feature macro PS2_TX_ACK_CHECK_EN adds ack_err, flagging a missing device acknowledge.
module ps2_tx #(
    parameter int RTS_CYCLES = 5000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2d,
    inout  wire        ps2c,
    output logic       tx_idle,
    output logic       tx_done_tick,
`ifdef PS2_TX_ACK_CHECK_EN
    output logic       ack_err,
`endif
    output logic [2:0] state_dbg
);
    localparam int RW = $clog2(RTS_CYCLES);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} state_t;

    state_t                state_reg, state_next;
    logic [FILTER_LEN-1:0] filter_reg, filter_next;
    logic                  f_ps2c_reg, f_ps2c_next;
    logic                  fall_edge;
    logic [RW-1:0]         rts_cnt, rts_next;
    logic [3:0]            n_reg, n_next;
    logic [8:0]            b_reg, b_next;
    logic                  c_low, d_low;

    // Glitch filter: the filtered clock only changes once FILTER_LEN identical samples agree.
    assign filter_next = {ps2c, filter_reg[FILTER_LEN-1:1]};

    always_comb begin
        f_ps2c_next = f_ps2c_reg;
        if (&filter_next)
            f_ps2c_next = 1'b1;
        else if (~|filter_next)
            f_ps2c_next = 1'b0;
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            filter_reg <= '1;
            f_ps2c_reg <= 1'b1;
            rts_cnt    <= '0;
            n_reg      <= '0;
            b_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            filter_reg <= filter_next;
            f_ps2c_reg <= f_ps2c_next;
            rts_cnt    <= rts_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
        end
    end

    // Handshake: wr_ps2 is a single-cycle request, accepted only when tx_idle is 1 in that
    // same cycle; otherwise it is dropped. Completion is signalled by tx_done_tick.
    always_comb begin
        state_next   = state_reg;
        rts_next     = rts_cnt;
        n_next       = n_reg;
        b_next       = b_reg;
        tx_idle      = 1'b0;
        tx_done_tick = 1'b0;
        c_low        = 1'b0;
        d_low        = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_idle = 1'b1;
                if (wr_ps2) begin
                    b_next     = {~^din, din};
                    rts_next   = '0;
                    state_next = RTS;
                end
            end
            RTS: begin
                // Our own low drive creates clock edges here; they are deliberately not watched.
                c_low = 1'b1;
                if (rts_cnt == RW'(RTS_CYCLES - 1))
                    state_next = START;
                else
                    rts_next = rts_cnt + 1'b1;
            end
            START: begin
                d_low = 1'b1;
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = DATA;
                end
            end
            DATA: begin
                d_low = ~b_reg[0];
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0)
                        state_next = STOP;
                    else
                        n_next = n_reg - 1'b1;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    state_next   = IDLE;
                    tx_done_tick = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PS2_TX_ACK_CHECK_EN
    logic [1:0] d_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_sync  <= 2'b11;
            ack_err <= 1'b0;
        end else begin
            d_sync <= {ps2d, d_sync[1]};
            if (tx_done_tick)
                ack_err <= d_sync[0];
        end
    end
`endif

    assign ps2c      = c_low ? 1'b0 : 1'bz;
    assign ps2d      = d_low ? 1'b0 : 1'bz;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device clocks frames out of the host and decodes them;
// expected frames come from a parity model and are queued when each command is issued.
module tb_ps2_tx;
    localparam int RTS  = 50;
    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    wire        ps2d;
    wire        ps2c;
    logic       tx_idle;
    logic       tx_done_tick;
    logic [2:0] state_dbg;
`ifdef PS2_TX_ACK_CHECK_EN
    logic       ack_err;
`endif

    logic dev_c_low = 1'b0, dev_d_low = 1'b0;
    logic dev_abort = 1'b0, dev_busy = 1'b0;
    logic dev_glitch = 1'b0, dev_no_ack = 1'b0;
    int   dev_bits = 0;

    logic [10:0] exp_q[$];
    int vectors = 0, miscompares = 0;
    int tick_cnt = 0, exp_ticks = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    ps2_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(8)) dut (
        .clk(clk),
        .reset(reset),
        .wr_ps2(wr_ps2),
        .din(din),
        .ps2d(ps2d),
        .ps2c(ps2c),
        .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick),
`ifdef PS2_TX_ACK_CHECK_EN
        .ack_err(ack_err),
`endif
        .state_dbg(state_dbg)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Wire order as the device sees it: bit0 start, bits1-8 data LSB first, bit9 parity, bit10 stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int k = 0; k < 8; k++)
            if (b[k]) ones++;
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic dev_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (dev_abort) return;
        end
    endtask

    // Device model: measures RTS, clocks 10 bits sampling on rising edges, then acks.
    initial begin : device
        logic [10:0] rx;
        int len;
        forever begin
            @(negedge clk);
            if (!reset && !dev_abort && ps2c === 1'b0 && !dev_c_low) begin
                dev_busy = 1'b1;
                len = 0;
                while (ps2c === 1'b0 && len < 4 * RTS) begin
                    len++;
                    @(negedge clk);
                end
                check("rts_len", len, RTS);
                rx = '0;
                rx[0] = ps2d;
                if (dev_glitch) begin
                    dev_wait(15);
                    dev_c_low = 1'b1;
                    dev_wait(3);
                    dev_c_low = 1'b0;
                    dev_wait(HALF - 18);
                end else begin
                    dev_wait(HALF);
                end
                for (int i = 1; i <= 10 && !dev_abort; i++) begin
                    dev_c_low = 1'b1;
                    dev_bits = i;
                    dev_wait(HALF);
                    dev_c_low = 1'b0;
                    rx[i] = ps2d;
                    dev_wait(HALF);
                end
                if (!dev_abort) begin
                    dev_d_low = !dev_no_ack;
                    dev_wait(5);
                    dev_c_low = 1'b1;
                    dev_wait(HALF);
                    dev_c_low = 1'b0;
                    dev_d_low = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_unexpected: got %03h with nothing expected", rx);
                    end else begin
                        check("frame", rx, exp_q.pop_front());
                    end
                end
                dev_c_low = 1'b0;
                dev_d_low = 1'b0;
                dev_busy = 1'b0;
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (tx_done_tick) begin
                tick_cnt++;
                @(negedge clk);
                check("idle_after_done", tx_idle, 1);
            end
        end
    end

    task automatic start_tx(input logic [7:0] b, input bit expect_done);
        for (int i = 0; i < 2000 && !tx_idle; i++) @(negedge clk);
        dev_bits = 0;
        wr_ps2 = 1'b1;
        din = b;
        if (expect_done) begin
            exp_q.push_back(frame_of(b));
            exp_ticks++;
        end
        @(negedge clk);
        wr_ps2 = 1'b0;
        din = 8'($urandom_range(0, 255));
        check("busy_after_wr", tx_idle, 0);
    endtask

    task automatic wait_done(input bit poke);
        bit seen = 0;
        int busy_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (tx_done_tick) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
        if (seen && poke) begin
            wr_ps2 = 1'b1;
            din = 8'h55;
            @(negedge clk);
            wr_ps2 = 1'b0;
            repeat (100) begin
                if (!tx_idle) busy_cycles++;
                @(negedge clk);
            end
            check("wr_on_tick_ignored", busy_cycles, 0);
        end
        for (int i = 0; i < 300 && dev_busy; i++) @(negedge clk);
        check("device_finished", dev_busy, 0);
`ifdef PS2_TX_ACK_CHECK_EN
        check("ack_err", ack_err, dev_no_ack);
`endif
    endtask

    task automatic send(input logic [7:0] b);
        start_tx(b, 1);
        wait_done(0);
    endtask

    initial begin : main
        int ticks_before;
        bit reached;

        repeat (3) @(negedge clk);
        check("reset_idle", tx_idle, 1);
        check("reset_tick", tx_done_tick, 0);
        check("reset_ps2c", ps2c, 1);
        check("reset_ps2d", ps2d, 1);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #5 reset = 1'b1;
        #1;
        check("midclk_reset_state", state_dbg, 0);
        check("midclk_reset_idle", tx_idle, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hED);
        send(8'h00);
        send(8'hFF);
        send(8'h01);

        dev_glitch = 1'b1;
        send(8'h5A);
        dev_glitch = 1'b0;

        // Busy rejection while the device is clocking data bits.
        start_tx(8'hF4, 1);
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            if (dev_bits >= 3) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        check("reach_data_busy", reached, 1);
        wr_ps2 = 1'b1;
        din = 8'hAA;
        @(negedge clk);
        wr_ps2 = 1'b0;
        wait_done(0);

        start_tx(8'h3C, 1);
        wait_done(1);

        // Reset during DATA after bit 3; all-zero byte keeps the host pulling data low.
        ticks_before = tick_cnt;
        start_tx(8'h00, 0);
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            if (dev_bits >= 4 && !dev_c_low) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        check("reach_data_abort", reached, 1);
        check("pre_abort_data_low", ps2d, 0);
        #3 reset = 1'b1;
        dev_abort = 1'b1;
        #1;
        check("abort_ps2d_released", ps2d, 1);
        check("abort_ps2c_released", ps2c, 1);
        check("abort_idle", tx_idle, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 300 && dev_busy; i++) @(negedge clk);
        dev_abort = 1'b0;
        repeat (200) @(negedge clk);
        check("no_tick_on_abort", tick_cnt, ticks_before);
        send(8'hFF);

`ifdef PS2_TX_ACK_CHECK_EN
        dev_no_ack = 1'b1;
        send(8'hF4);
        dev_no_ack = 1'b0;
        send(8'hF4);
`endif

        for (int n = 0; n < 8; n++) begin
            dev_glitch = ($urandom_range(0, 3) == 0);
            send(8'($urandom_range(0, 255)));
        end
        dev_glitch = 1'b0;

        repeat (20) @(negedge clk);
        check("tick_total", tick_cnt, exp_ticks);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
